// File: rtl/exc_commit.sv
// Writeback commit and exception arbiter: latches the MEM beat, prioritises interrupts and
// exceptions, drives CSR/GPR writes, flushes the pipe and holds the IF redirect. Optional counters: EXC_COMMIT_PERF_EN.
//
//   state | meaning
//   RUN   | normal commit; a flush here loads redirect_pc and moves to REDIR
//   REDIR | redirect_valid high, redirect_pc held; incoming beats are dropped
module exc_commit #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ms_to_ws_valid,
    output logic              ws_allow_in,
    input  logic [31:0]       ms_pc,
    input  logic [4:0]        ms_ex,
    input  logic [31:0]       ms_vaddr,
    input  logic              ms_is_ertn,
    input  logic              ms_csr_we,
    input  logic [13:0]       ms_csr_num,
    input  logic [31:0]       ms_csr_wmask,
    input  logic [31:0]       ms_csr_wvalue,
    input  logic              ms_rf_we,
    input  logic [4:0]        ms_rf_waddr,
    input  logic [31:0]       ms_rf_wdata,
    input  logic              has_int,
    input  logic [31:0]       csr_eentry_data,
    input  logic [31:0]       csr_era_pc,
    output logic              wb_ex,
    output logic              ertn_flush,
    output logic [5:0]        wb_ecode,
    output logic [8:0]        wb_esubcode,
    output logic [31:0]       wb_pc,
    output logic [31:0]       wb_vaddr,
    output logic              csr_we,
    output logic [13:0]       csr_num,
    output logic [31:0]       csr_wmask,
    output logic [31:0]       csr_wvalue,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [31:0]       rf_wdata,
    output logic              flush_pipe,
    output logic              redirect_valid,
    output logic [31:0]       redirect_pc,
    input  logic              redirect_ready,
    output logic [PERF_W-1:0] perf_inst_cnt,
    output logic [PERF_W-1:0] perf_exc_cnt
);

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_REDIR = 1'b1;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    logic [0:0]  state;

    logic        ws_valid;
    logic [31:0] ws_pc;
    logic [4:0]  ws_ex;
    logic [31:0] ws_vaddr;
    logic        ws_is_ertn;
    logic        ws_csr_we;
    logic [13:0] ws_csr_num;
    logic [31:0] ws_csr_wmask;
    logic [31:0] ws_csr_wvalue;
    logic        ws_rf_we;
    logic [4:0]  ws_rf_waddr;
    logic [31:0] ws_rf_wdata;

    logic        in_run;
    logic        accept;
    logic        int_take;
    logic        exc_hit;
    logic        ex_take;
    logic        commit_ok;

    assign ws_allow_in = 1'b1;
    assign accept      = ms_to_ws_valid && ws_allow_in;

    // A beat arriving while flushing or redirecting is younger than the
    // faulting/ertn instruction and must never reach commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid      <= 1'b0;
            ws_pc         <= '0;
            ws_ex         <= '0;
            ws_vaddr      <= '0;
            ws_is_ertn    <= 1'b0;
            ws_csr_we     <= 1'b0;
            ws_csr_num    <= '0;
            ws_csr_wmask  <= '0;
            ws_csr_wvalue <= '0;
            ws_rf_we      <= 1'b0;
            ws_rf_waddr   <= '0;
            ws_rf_wdata   <= '0;
        end else begin
            ws_valid <= accept && in_run && !flush_pipe;
            if (accept) begin
                ws_pc         <= ms_pc;
                ws_ex         <= ms_ex;
                ws_vaddr      <= ms_vaddr;
                ws_is_ertn    <= ms_is_ertn;
                ws_csr_we     <= ms_csr_we;
                ws_csr_num    <= ms_csr_num;
                ws_csr_wmask  <= ms_csr_wmask;
                ws_csr_wvalue <= ms_csr_wvalue;
                ws_rf_we      <= ms_rf_we;
                ws_rf_waddr   <= ms_rf_waddr;
                ws_rf_wdata   <= ms_rf_wdata;
            end
        end
    end

    assign in_run    = (state == S_RUN);
    assign int_take  = ws_valid && has_int && in_run;
    assign exc_hit   = ws_valid && (|ws_ex) && in_run;
    assign ex_take   = int_take || exc_hit;
    assign commit_ok = ws_valid && !ex_take && in_run;

    // ws_ex = {ale, brk, sys, ine, adef}; interrupt outranks every flag.
    always_comb begin
        wb_ecode = 6'h00;
        if (int_take)
            wb_ecode = ECODE_INT;
        else if (exc_hit) begin
            if (ws_ex[0])
                wb_ecode = ECODE_ADEF;
            else if (ws_ex[1])
                wb_ecode = ECODE_INE;
            else if (ws_ex[2])
                wb_ecode = ECODE_SYS;
            else if (ws_ex[3])
                wb_ecode = ECODE_BRK;
            else
                wb_ecode = ECODE_ALE;
        end
    end

    assign wb_esubcode = 9'h000;
    assign wb_ex       = ex_take;
    assign wb_pc       = ws_pc;
    assign wb_vaddr    = ws_vaddr;
    assign ertn_flush  = ws_valid && ws_is_ertn && !ex_take && in_run;
    assign flush_pipe  = ex_take || ertn_flush;

    assign csr_we     = commit_ok && ws_csr_we;
    assign csr_num    = ws_csr_num;
    assign csr_wmask  = ws_csr_wmask;
    assign csr_wvalue = ws_csr_wvalue;
    assign rf_we      = commit_ok && ws_rf_we;
    assign rf_waddr   = ws_rf_waddr;
    assign rf_wdata   = ws_rf_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_RUN;
            redirect_pc <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (flush_pipe) begin
                        state       <= S_REDIR;
                        redirect_pc <= ex_take ? csr_eentry_data : csr_era_pc;
                    end
                end
                S_REDIR: begin
                    if (redirect_ready)
                        state <= S_RUN;
                end
                default: state <= S_RUN;
            endcase
        end
    end

    assign redirect_valid = (state == S_REDIR);

`ifdef EXC_COMMIT_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_inst_cnt <= '0;
            perf_exc_cnt  <= '0;
        end else begin
            if (commit_ok)
                perf_inst_cnt <= perf_inst_cnt + 1'b1;
            if (ex_take)
                perf_exc_cnt <= perf_exc_cnt + 1'b1;
        end
    end
`else
    assign perf_inst_cnt = '0;
    assign perf_exc_cnt  = '0;
`endif

endmodule

// File: doc/exc_commit.md
# exc_commit

Writeback-stage commit and exception arbiter for the LoongArch pipeline. Latches the MEM-stage beat, takes interrupts, prioritises exceptions, and drives the CSR file's exception/ertn/write inputs. Commits register-file writes, flushes the upstream pipeline, and holds a PC redirect toward IF until IF accepts it.

## Interface
Parameters:
- PERF_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ms_to_ws_valid  in  1  MEM beat valid
- ws_allow_in  out  1  WB accepts a beat
- ms_pc  in  32  instruction PC
- ms_ex  in  5  exception flags {ale, brk, sys, ine, adef}
- ms_vaddr  in  32  load/store address
- ms_is_ertn  in  1  instruction is ertn
- ms_csr_we / ms_csr_num / ms_csr_wmask / ms_csr_wvalue  in  1/14/32/32  CSR write request
- ms_rf_we / ms_rf_waddr / ms_rf_wdata  in  1/5/32  GPR write
- has_int / csr_eentry_data / csr_era_pc  in  1/32/32  from CSR file
- wb_ex / ertn_flush  out  1/1  to CSR file
- wb_ecode / wb_esubcode / wb_pc / wb_vaddr  out  6/9/32/32  to CSR file
- csr_we / csr_num / csr_wmask / csr_wvalue  out  1/14/32/32  to CSR file
- rf_we / rf_waddr / rf_wdata  out  1/5/32  GPR write port
- flush_pipe  out  1  kill IF..MEM
- redirect_valid / redirect_pc  out  1/32  IF redirect request
- redirect_ready  in  1  IF accepts redirect
- perf_inst_cnt / perf_exc_cnt  out  PERF_W  counters

## Operation
- WB register: loads when ms_to_ws_valid && ws_allow_in. ws_valid then marks the held beat.
- ws_allow_in is always 1. WB completes in one cycle.
- Beats accepted while in state REDIR are discarded; ws_valid stays 0.
- Interrupt: int_take = ws_valid && has_int && state==RUN. The interrupt is charged to the WB instruction: wb_pc is its PC and it does not commit.
- Priority, highest first:
  - INT: ecode 0x00
  - ADEF: ecode 0x08, subcode 0
  - INE: ecode 0x0D
  - SYS: ecode 0x0B
  - BRK: ecode 0x0C
  - ALE: ecode 0x09
- esubcode is 0 for every case.
- ex_take = int_take || (ws_valid && |ws_ex && state==RUN).
- wb_ex = ex_take. wb_ecode/wb_esubcode come from the winning entry; when ex_take=0 they are 0.
- wb_pc = ws_pc; wb_vaddr = ws_vaddr.
- ertn_flush = ws_valid && ws_is_ertn && !ex_take && state==RUN. An exception beats ertn.
- Commit writes are gated by commit_ok = ws_valid && !ex_take && state==RUN:
  - rf_we = commit_ok && ws_rf_we.
  - csr_we = commit_ok && ws_csr_we.
  - Address and data outputs pass straight through.
- flush_pipe = ex_take || ertn_flush (combinational, same cycle).
- FSM:
  - RUN → REDIR on flush_pipe. redirect_pc is loaded with csr_eentry_data (exception) or csr_era_pc (ertn), sampled in the commit cycle.
  - REDIR: redirect_valid=1; redirect_pc is held stable.
  - REDIR → RUN on redirect_ready.
- has_int is ignored in REDIR and whenever ws_valid=0.

## Timing
- Reset values:
  - Registers: ws_valid=0, state=RUN, redirect_pc=0, perf counters 0.
  - Outputs: every combinational output above is 0 during reset, since ws_valid=0 and redirect_valid=0.
- Commit cycle N: CSR and GPR writes take effect at edge N→N+1. flush_pipe is high in N. redirect_valid goes high from N+1.
- The redirect is held until redirect_ready is seen high at a rising edge. With ready already high, the minimum REDIR time is 1 cycle.
- ws_valid of a REDIR-period beat never reaches commit. The first new beat can be accepted in the cycle state returns to RUN.
- Reset asserted in REDIR: next cycle state=RUN and redirect_valid=0.
- Simultaneous has_int and ertn: INT wins. redirect_pc = csr_eentry_data, ertn_flush=0.

## Configuration
- EXC_COMMIT_PERF_EN defined: both counters are active and wrap modulo 2^PERF_W.
  - perf_inst_cnt increments on each commit_ok cycle, which includes ertn.
  - perf_exc_cnt increments on each ex_take.
- EXC_COMMIT_PERF_EN undefined: no counter flops; both outputs are tied to 0.

## Test plan
- Plain commit: beat pc=0x1c000000, rf_we=1, waddr=5, wdata=0x1234 → rf_we high for 1 cycle with those values; wb_ex=0, flush_pipe=0, redirect_valid stays 0.
- SYS: beat pc=0x1c000010, ms_ex=00100, csr_eentry_data=0x1c008000 → in cycle N: wb_ex=1, ecode=0x0B, rf_we=0, flush_pipe=1. From N+1: redirect_valid=1, redirect_pc=0x1c008000. redirect_ready held low 3 cycles → redirect held 3+ cycles.
- Priority: ms_ex=11001 (ale, brk, adef) → ecode=0x08, subcode=0. The same beat with has_int=1 → ecode=0x00, wb_pc=its PC.
- ERTN: ms_is_ertn=1, csr_era_pc=0x1c000024 → ertn_flush=1, wb_ex=0, then redirect_pc=0x1c000024. ertn together with ms_ex=ine → wb_ex=1, ecode=0x0D, ertn_flush=0.
- REDIR drop and reset: a beat arrives during REDIR → no rf_we/csr_we afterward. Reset pulsed while in REDIR → redirect_valid=0 next cycle.
- Perf: 10 commits + 2 exceptions → with EXC_COMMIT_PERF_EN, counts 10/2; without it, counts 0/0.
